// File: rtl/fp_digit_pkg.sv
// fp_digit_pkg
// Shared constants for the float32 digit extractor: IEEE-754 single field
// positions, exponent bias, fixed-point geometry and the exponent window
// that yields a meaningful key. Also the stage-1 record carried by each lane.
// No ports (package).
package fp_digit_pkg;

    localparam int SIGN_BIT  = 31;
    localparam int EXP_MSB   = 30;
    localparam int EXP_LSB   = 23;
    localparam int MAN_MSB   = 22;
    localparam int EXP_W     = 8;
    localparam int MAN_W     = 23;
    localparam int BIAS      = 127;

    localparam int FRAC_BITS = 23;
    localparam int FX_W      = 56;
    localparam int PROD_W    = 72;
    localparam int INT_W     = PROD_W - FRAC_BITS;
    localparam int SHAMT_W   = 5;

    localparam int E_MIN     = -23;
    localparam int E_MAX     = 31;
    localparam int MAX_CH    = 8;

    // Raw exponent-field equivalents of the unbiased limits, so the lanes can
    // classify inputs with plain unsigned compares on the 8-bit field.
    localparam logic [EXP_W-1:0] EXP_BIAS = EXP_W'(BIAS);
    localparam logic [EXP_W-1:0] EXP_LO   = EXP_W'(BIAS + E_MIN);
    localparam logic [EXP_W-1:0] EXP_HI   = EXP_W'(BIAS + E_MAX);

    typedef struct packed {
        logic [MAN_W:0]         mant;
        logic                   left;
        logic [SHAMT_W-1:0]     shamt;
        logic                   zero;
        logic                   err;
    } s1_t;

endpackage

// File: rtl/fp_digit_lane.sv
// fp_digit_lane
// Single-channel datapath: key = floor(|x| * SCALE) mod MOD in four stages
// (unpack, align to 23-bit-fraction fixed point, scale, modulo).
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-low reset, clears every stage register
//   en    - stage enable; all four stages advance together when high
//   x     - IEEE-754 single (sign ignored)
//   key   - extracted key word, OUT_W bits
//   err   - exception flag (Inf, NaN or finite overflow)
module fp_digit_lane
    import fp_digit_pkg::*;
#(
    parameter int unsigned SCALE = 1000,
    parameter int unsigned MOD   = 1000,
    parameter int          OUT_W = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [31:0]      x,
    output logic [OUT_W-1:0] key,
    output logic             err
);

    localparam logic [PROD_W-1:0] SCALE_X = PROD_W'(SCALE);
    localparam logic [INT_W-1:0]  MOD_X   = INT_W'(MOD);

    logic [EXP_W-1:0]  exp_field;
    logic              unused_sign;
    s1_t               s1;
    logic [FX_W-1:0]   fx_next;
    logic [FX_W-1:0]   s2_fx;
    logic              s2_err;
    logic [PROD_W-1:0] prod;
    logic [INT_W-1:0]  s3_int;
    logic              s3_err;

    assign exp_field = x[EXP_MSB:EXP_LSB];

    // The key is taken from |x|, so the sign bit is intentionally dropped.
    assign unused_sign = x[SIGN_BIT];

    // Zero, denormal, underflow and every exception collapse to fx = 0, which
    // forces the downstream key to 0 without any extra muxing later on.
    always_comb begin
        fx_next = '0;
        if (!(s1.zero || s1.err)) begin
            if (s1.left) begin
                fx_next = FX_W'(s1.mant) << s1.shamt;
            end else begin
                fx_next = FX_W'(s1.mant) >> s1.shamt;
            end
        end
    end

    assign prod = PROD_W'(s2_fx) * SCALE_X;

    // exp = 0 (zero/denormal) falls below EXP_LO and exp = 255 (Inf/NaN)
    // lies above EXP_HI, so two compares cover every special class.
    // The shift amount is only meaningful inside the window; outside it the
    // zero/err flags mask the aligned value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1     <= '0;
            s2_fx  <= '0;
            s2_err <= 1'b0;
            s3_int <= '0;
            s3_err <= 1'b0;
            key    <= '0;
            err    <= 1'b0;
        end else if (en) begin
            s1.mant  <= {exp_field != '0, x[MAN_MSB:0]};
            s1.left  <= exp_field >= EXP_BIAS;
            s1.shamt <= (exp_field >= EXP_BIAS) ? SHAMT_W'(exp_field - EXP_BIAS)
                                                : SHAMT_W'(EXP_BIAS - exp_field);
            s1.zero  <= exp_field < EXP_LO;
            s1.err   <= exp_field > EXP_HI;

            s2_fx    <= fx_next;
            s2_err   <= s1.err;

            s3_int   <= INT_W'(prod >> FRAC_BITS);
            s3_err   <= s2_err;

            key      <= OUT_W'(s3_int % MOD_X);
            err      <= s3_err;
        end
    end

endmodule

// File: rtl/fp_digit_extractor.sv
// fp_digit_extractor
// N_CH float32 channels processed in lockstep through a 4-stage pipeline with
// valid/ready handshakes on both sides, a flush and an output handshake counter.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-low reset
//   flush      - synchronous pipeline clear, active-high
//   in_valid   - in_data holds a vector
//   in_ready   - vector accepted this cycle
//   in_data    - N_CH packed singles, channel k at [32k+31:32k]
//   out_valid  - out_data/out_err valid
//   out_ready  - downstream accepts this cycle
//   out_data   - N_CH packed keys, channel k at [OUT_W*k+OUT_W-1:OUT_W*k]
//   out_err    - per-channel exception flags
//   out_count  - completed output handshakes, wraps at 2^32
module fp_digit_extractor
    import fp_digit_pkg::*;
#(
    parameter int          N_CH  = 3,
    parameter int          OUT_W = 23,
    parameter int unsigned SCALE = 1000,
    parameter int unsigned MOD   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_CH*32-1:0]    in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_CH*OUT_W-1:0] out_data,
    output logic [N_CH-1:0]       out_err,
    output logic [31:0]           out_count
);

    if (N_CH < 1 || N_CH > MAX_CH) begin : g_bad_nch
        $error("fp_digit_extractor: N_CH must be in 1..8");
    end
    if (SCALE == 0 || SCALE > 65535) begin : g_bad_scale
        $error("fp_digit_extractor: SCALE must be in 1..65535");
    end
    if (64'(MOD) > (64'd1 << OUT_W)) begin : g_bad_mod
        $error("fp_digit_extractor: MOD exceeds 2^OUT_W");
    end

    logic       advance;
    logic [3:1] stage_valid;

    // The whole pipeline moves as one; a stalled output freezes every stage.
    assign advance  = !out_valid || out_ready;
    assign in_ready = rst && advance && !flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_valid <= '0;
            out_valid   <= 1'b0;
            out_count   <= '0;
        end else begin
            if (flush) begin
                stage_valid <= '0;
                out_valid   <= 1'b0;
            end else if (advance) begin
                stage_valid <= {stage_valid[2:1], in_valid && in_ready};
                out_valid   <= stage_valid[3];
            end
            if (out_valid && out_ready) begin
                out_count <= out_count + 32'd1;
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        fp_digit_lane #(
            .SCALE (SCALE),
            .MOD   (MOD),
            .OUT_W (OUT_W)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (advance),
            .x   (in_data[32*k +: 32]),
            .key (out_data[OUT_W*k +: OUT_W]),
            .err (out_err[k])
        );
    end

endmodule

// File: tb/tb_fp_digit_extractor.sv
// tb_fp_digit_extractor
// Randomized and directed bench for fp_digit_extractor. Expected keys come
// from a real-valued reference model (float -> double conversion, scaling
// and modulo) kept in a scoreboard queue; a negedge monitor checks every
// output handshake, stall stability and the handshake counter.
module tb_fp_digit_extractor;

    localparam int NCH = 3;
    localparam int OW  = 23;
    localparam int SC  = 1000;
    localparam int MD  = 1000;
    localparam int DW  = NCH * 32;
    localparam int KW  = NCH * OW;

    typedef struct packed {
        logic [KW-1:0]  data;
        logic [NCH-1:0] err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          inValid;
    logic          inReady;
    logic [DW-1:0] inData;
    logic          outValid;
    logic          outReady;
    logic [KW-1:0] outData;
    logic [NCH-1:0] outErr;
    logic [31:0]   outCount;

    logic          p2InValid;
    logic          p2InReady;
    logic [31:0]   p2InData;
    logic          p2OutValid;
    logic [7:0]    p2OutData;
    logic [0:0]    p2OutErr;
    logic [31:0]   p2OutCount;

    int            total = 0;
    int            bad = 0;
    exp_t          expQ[$];
    logic [31:0]   expCount = 0;
    int            outsSeen = 0;
    bit            holdValid = 0;
    logic [KW-1:0] holdData;
    logic [NCH-1:0] holdErr;

    always #5 clk = ~clk;

    fp_digit_extractor #(.N_CH(NCH), .OUT_W(OW), .SCALE(SC), .MOD(MD)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .out_err   (outErr),
        .out_count (outCount)
    );

    fp_digit_extractor #(.N_CH(1), .OUT_W(8), .SCALE(100), .MOD(256)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .in_valid  (p2InValid),
        .in_ready  (p2InReady),
        .in_data   (p2InData),
        .out_valid (p2OutValid),
        .out_ready (1'b1),
        .out_data  (p2OutData),
        .out_err   (p2OutErr),
        .out_count (p2OutCount)
    );

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Exact value of a normal single as a real; zero and denormals give 0.
    function automatic real floatToReal(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) return 0.0;
        d = {1'b0, 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Reference: magnitude truncated to 23 fractional bits, scaled, floored, mod.
    function automatic void refLane(input logic [31:0] b, input int scale, input int modv,
                                    output longint key, output bit err);
        real mag;
        real fx;
        real scaled;
        key = 0;
        err = 0;
        if (b[30:23] == 8'hFF) begin
            err = 1;
            return;
        end
        mag = floatToReal(b);
        if (mag >= 4294967296.0) begin
            err = 1;
            return;
        end
        fx     = $floor(mag * 8388608.0);
        scaled = $floor(fx * real'(scale) / 8388608.0);
        key    = longint'(scaled) % longint'(modv);
    endfunction

    function automatic exp_t refVector(input logic [DW-1:0] v);
        exp_t   e;
        longint key;
        bit     err;
        e = '0;
        for (int k = 0; k < NCH; k++) begin
            refLane(v[32*k +: 32], SC, MD, key, err);
            e.data[OW*k +: OW] = OW'(key);
            e.err[k] = err;
        end
        return e;
    endfunction

    function automatic logic [31:0] randFloat();
        int         sel;
        logic [7:0] e;
        sel = $urandom_range(0, 19);
        case (sel)
            0:       e = 8'd0;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(159, 200));
            3:       e = 8'($urandom_range(80, 103));
            4:       e = 8'(($urandom_range(0, 1) != 0) ? 104 : 158);
            default: e = 8'($urandom_range(104, 158));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    function automatic logic [DW-1:0] randVector();
        logic [DW-1:0] v;
        for (int k = 0; k < NCH; k++) v[32*k +: 32] = randFloat();
        return v;
    endfunction

    // Presents one vector until it is accepted; call at posedge+1.
    task automatic applyStimulus(input logic [DW-1:0] d);
        int waitCycles;
        waitCycles = 0;
        inValid = 1'b1;
        inData  = d;
        do begin
            @(negedge clk);
            waitCycles++;
        end while (!inReady && waitCycles < 50);
        if (!inReady) checkOutput("in_ready_timeout", inReady, 1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || outValid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_empty", expQ.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic runDirected(input string tag, input logic [DW-1:0] vec,
                               input logic [KW-1:0] keys, input logic [NCH-1:0] errs);
        int lat;
        applyStimulus(vec);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!outValid && lat < 12);
        checkOutput({tag, "_latency"}, lat, 4);
        checkOutput({tag, "_keys"}, outData, keys);
        checkOutput({tag, "_err"}, outErr, errs);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: sees each edge's handshakes half a cycle early.
    always @(negedge clk) begin
        exp_t e;
        if (holdValid) begin
            checkOutput("stall_valid", outValid, 1);
            checkOutput("stall_data", outData, holdData);
            checkOutput("stall_err", outErr, holdErr);
        end
        holdValid = rst && !flush && outValid && !outReady;
        holdData  = outData;
        holdErr   = outErr;
        if (rst && outValid && outReady) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_output", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("out_data", outData, e.data);
                checkOutput("out_err", outErr, e.err);
            end
            checkOutput("out_count", outCount, expCount);
            expCount = expCount + 32'd1;
            outsSeen++;
        end
        if (rst && inValid && inReady) expQ.push_back(refVector(inData));
        if (!rst || flush) expQ.delete();
        if (!rst) expCount = 0;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] cntBase;
        int          seenBase;
        int          n;

        rst       = 1'b0;
        flush     = 1'b0;
        inValid   = 1'b0;
        inData    = '0;
        outReady  = 1'b1;
        p2InValid = 1'b0;
        p2InData  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_out_data", outData, 0);
        checkOutput("rst_out_err", outErr, 0);
        checkOutput("rst_out_count", outCount, 0);
        checkOutput("rst_in_ready", inReady, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_after_rst", inReady, 1);
        @(posedge clk);
        #1;

        $display("[TB] directed vectors");
        runDirected("basic", {32'h40490FDB, 32'h3F000000, 32'hC0300000},
                    {23'd141, 23'd500, 23'd750}, 3'b000);
        @(negedge clk);
        checkOutput("count_after_first", outCount, 1);
        @(posedge clk);
        #1;
        runDirected("except", {32'h7F800000, 32'h501502F9, 32'h00000001},
                    {23'd0, 23'd0, 23'd0}, 3'b110);
        runDirected("edges", {32'h4F000000, 32'h34000000, 32'h33FFFFFF},
                    {23'd0, 23'd0, 23'd0}, 3'b000);
        waitDrain();

        $display("[TB] back-to-back with stall");
        cntBase  = expCount;
        seenBase = outsSeen;
        fork
            begin
                for (int i = 0; i < 10; i++) applyStimulus(randVector());
            end
            begin
                repeat (6) @(posedge clk);
                #1 outReady = 1'b0;
                repeat (3) @(posedge clk);
                #1 outReady = 1'b1;
            end
        join
        waitDrain();
        checkOutput("stall_outs_seen", outsSeen - seenBase, 10);
        checkOutput("stall_count", outCount, cntBase + 32'd10);

        $display("[TB] flush with vectors in flight");
        cntBase  = expCount;
        seenBase = outsSeen;
        for (int i = 0; i < 3; i++) applyStimulus(randVector());
        inValid = 1'b1;
        inData  = randVector();
        flush   = 1'b1;
        @(negedge clk);
        checkOutput("flush_in_ready", inReady, 0);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        inValid = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("flush_no_outputs", outsSeen - seenBase, 0);
        checkOutput("flush_count", outCount, cntBase);
        @(posedge clk);
        #1;

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 5; i++) applyStimulus(randVector());
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        seenBase = outsSeen;
        @(negedge clk);
        checkOutput("midrst_out_valid", outValid, 0);
        checkOutput("midrst_out_data", outData, 0);
        checkOutput("midrst_out_err", outErr, 0);
        checkOutput("midrst_out_count", outCount, 0);
        checkOutput("midrst_in_ready", inReady, 1);
        repeat (8) @(negedge clk);
        checkOutput("midrst_no_outputs", outsSeen - seenBase, 0);
        @(posedge clk);
        #1;

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            inValid  = ($urandom_range(0, 3) != 0);
            inData   = randVector();
            outReady = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 40) == 0);
            @(posedge clk);
            #1;
        end
        inValid  = 1'b0;
        flush    = 1'b0;
        outReady = 1'b1;
        waitDrain();
        checkOutput("final_count", outCount, expCount);

        $display("[TB] alternate parameter set");
        p2InValid = 1'b1;
        p2InData  = 32'h42F6E979;
        @(negedge clk);
        checkOutput("p2_in_ready", p2InReady, 1);
        @(posedge clk);
        #1;
        p2InValid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!p2OutValid && n < 12);
        checkOutput("p2_latency", n, 4);
        checkOutput("p2_key", p2OutData, 8'd57);
        checkOutput("p2_err", p2OutErr, 1'b0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_digit_extractor.md
FP_DIGIT_EXTRACTOR -- requirements
Module: fp_digit_extractor

Interface
REQ-001 Parameter N_CH, default 3, number of independent float32 channels (1..8).
REQ-002 Parameter OUT_W, default 23, width of each extracted key word.
REQ-003 Parameter SCALE, default 1000, decimal scale multiplier (1..65535).
REQ-004 Parameter MOD, default 1000, output modulus (2..2^OUT_W).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 flush  input  1  synchronous pipeline clear, active-high.
REQ-008 in_valid  input  1  in_data holds a valid N_CH-float vector.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 in_data  input  N_CH*32  packed IEEE-754 singles; channel k at bits [32k+31:32k].
REQ-011 out_valid  output  1  out_data/out_err valid.
REQ-012 out_ready  input  1  downstream accepts output this cycle.
REQ-013 out_data  output  N_CH*OUT_W  packed key words; channel k at [OUT_W*k+OUT_W-1:OUT_W*k].
REQ-014 out_err  output  N_CH  per-channel exception flag, aligned with out_data.
REQ-015 out_count  output  32  number of completed output handshakes.

Function
REQ-016 Input handshake occurs when in_valid and in_ready are both high; output handshake when out_valid and out_ready are both high.
REQ-017 Per channel, key = floor(|x| * SCALE) mod MOD, zero-extended to OUT_W; sign bit ignored.
REQ-018 Pipeline: S1 unpack (exp, mantissa with hidden bit, E = exp-127), S2 align to unsigned fixed point with 23 fraction bits (left shift for E>=0, truncating right shift for E<0), S3 multiply by SCALE then >>23, S4 mod MOD.
REQ-019 Latency SHALL be exactly 4 cycles from input handshake to out_valid when no stall occurs; throughput one vector per cycle.
REQ-020 Pipeline advances only when !out_valid or out_ready; in_ready equals that advance condition AND !flush.
REQ-021 Under stall (out_valid=1, out_ready=0), out_data, out_err and all stage contents SHALL hold unchanged.
REQ-022 Empty stages propagate as bubbles; out_valid is low for a bubble.
REQ-023 E < -23, zero, or denormal input: key 0, err 0.
REQ-024 E > 31 (finite overflow): key 0, err 1.
REQ-025 exp = 255 (Inf or NaN): key 0, err 1.
REQ-026 Fixed-point alignment width is 56 bits; S3 product width is 72 bits; no intermediate truncation besides the specified shifts.
REQ-027 flush clears every stage valid bit and out_valid on the next edge; data registers need not clear; out_count unaffected.
REQ-028 flush and an input presentation in the same cycle: input is not accepted (in_ready low).
REQ-029 out_count increments by 1 per output handshake, wraps 0xFFFFFFFF -> 0.
REQ-030 Channels are computed in lockstep; one channel's exception does not alter other channels.

Reset
REQ-031 When rst=0 at a rising edge: all stage valids, out_valid, out_data, out_err and out_count become 0.
REQ-032 in_ready is low while rst=0 and high on the first cycle after release (pipeline empty).
REQ-033 Reset mid-operation discards all in-flight vectors; no output handshake completes for them.

Structure
REQ-034 A shared package holds the float32 field positions, bias 127, FRAC_BITS 23, FX_W 56 and E range limits.
REQ-035 One sub-module fp_digit_lane (single-channel S1..S4 datapath with stage-enable input) is instantiated N_CH times; top holds valid chain, handshake and counter.
REQ-036 Elaboration SHALL fail if MOD > 2^OUT_W, SCALE = 0 or N_CH outside 1..8.

Verification
REQ-037 Defaults, in_data {0x40490FDB, 0x3F000000, 0xC0300000}, out_ready=1 -> 4 cycles later keys {141, 500, 750}, err 000, out_count 1.
REQ-038 Inputs {0x7F800000, 0x501502F9, 0x00000001} -> keys {0,0,0}, err {1,1,0}.
REQ-039 Ten back-to-back vectors, out_ready low for cycles 6-8 -> outputs held stable during stall, no loss or duplication, out_count 10.
REQ-040 Flush asserted with 3 vectors in flight and in_valid high -> no outputs from them, in_ready low that cycle, out_count unchanged.
REQ-041 rst low for 1 cycle mid-stream -> all outputs 0, out_valid 0, out_count 0, in_ready high next cycle.
REQ-042 N_CH=1, SCALE=100, MOD=256, OUT_W=8, input 0x42F6E979 (123.456) -> key 12345 mod 256 = 57, err 0.
